// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: shares the single USB transmit path between the data-path
// and control-path requesters. It grants one requester at a time
// (round-robin on ties), pulses start_tx to launch a transaction and waits
// for handshake_ack. A missing acknowledgement is retried after a backoff,
// up to MAX_RETRY times. After that the transaction is reported as failed.
module usb_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req_data,
  input  logic       req_ctrl,
  input  logic       handshake_ack,
  input  logic       idle_transmitting,
  output logic       grant_data,
  output logic       grant_ctrl,
  output logic       start_tx,
  output logic       done_data,
  output logic       done_ctrl,
  output logic       fail_data,
  output logic       fail_ctrl,
  output logic [1:0] retry_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_ACK = 3'd2,
    BACKOFF  = 3'd3,
    COMPLETE = 3'd4
  } state_t;

  localparam logic             LG_DATA      = 1'b0;
  localparam logic             LG_CTRL      = 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1'b1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  state_t           state_r, state_nxt;
  logic             last_grant_r, last_grant_nxt;
  logic [CNT_W-1:0] timer_r, timer_nxt;
  logic [1:0]       retry_r, retry_nxt;
  logic             success_r, success_nxt;
  logic             grant_data_r, grant_data_nxt;
  logic             grant_ctrl_r, grant_ctrl_nxt;
  logic             start_tx_r, start_tx_nxt;
  logic             done_data_r, done_data_nxt;
  logic             done_ctrl_r, done_ctrl_nxt;
  logic             fail_data_r, fail_data_nxt;
  logic             fail_ctrl_r, fail_ctrl_nxt;
  logic             enter_complete_s;
  logic             timeout_s;
  logic             data_wins_s;

  // The acknowledgement takes priority over a timeout in the same cycle.
  assign timeout_s   = (timer_r == TIMEOUT_LAST) && !handshake_ack;
  // A lone requester wins. On a tie, the requester not served last wins.
  assign data_wins_s = req_data && (!req_ctrl || (last_grant_r == LG_CTRL));

  // Next-state, grant, timer, retry and outcome logic
  always_comb begin
    state_nxt        = state_r;
    last_grant_nxt   = last_grant_r;
    timer_nxt        = timer_r;
    retry_nxt        = retry_r;
    success_nxt      = success_r;
    grant_data_nxt   = grant_data_r;
    grant_ctrl_nxt   = grant_ctrl_r;
    enter_complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_data || req_ctrl) begin
          state_nxt      = START;
          grant_data_nxt = data_wins_s;
          grant_ctrl_nxt = !data_wins_s;
          retry_nxt      = 2'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        state_nxt = WAIT_ACK;
        timer_nxt = {CNT_W{1'b0}};
      end
      WAIT_ACK: begin
        if (handshake_ack) begin
          state_nxt        = COMPLETE;
          success_nxt      = 1'b1;
          enter_complete_s = 1'b1;
        end else if (timeout_s) begin
          if (retry_r < RETRY_MAX) begin
            state_nxt = BACKOFF;
            retry_nxt = retry_r + 2'd1;
          end else begin
            state_nxt        = COMPLETE;
            success_nxt      = 1'b0;
            enter_complete_s = 1'b1;
          end
        end else begin
          timer_nxt = timer_r + TIMER_ONE;
        end
      end
      BACKOFF: begin
        if (idle_transmitting) begin
          state_nxt = START;
        end else begin
          state_nxt = BACKOFF;
        end
      end
      COMPLETE: begin
        state_nxt      = IDLE;
        last_grant_nxt = grant_ctrl_r ? LG_CTRL : LG_DATA;
        grant_data_nxt = 1'b0;
        grant_ctrl_nxt = 1'b0;
      end
      default: begin
        state_nxt      = IDLE;
        grant_data_nxt = 1'b0;
        grant_ctrl_nxt = 1'b0;
      end
    endcase
  end

  // Output pulse generation, registered so each pulse lines up with its state
  always_comb begin
    start_tx_nxt  = (state_nxt == START);
    done_data_nxt = enter_complete_s && success_nxt && grant_data_r;
    done_ctrl_nxt = enter_complete_s && success_nxt && grant_ctrl_r;
    fail_data_nxt = enter_complete_s && !success_nxt && grant_data_r;
    fail_ctrl_nxt = enter_complete_s && !success_nxt && grant_ctrl_r;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      last_grant_r <= LG_DATA;
      timer_r      <= {CNT_W{1'b0}};
      retry_r      <= 2'd0;
      success_r    <= 1'b0;
      grant_data_r <= 1'b0;
      grant_ctrl_r <= 1'b0;
      start_tx_r   <= 1'b0;
      done_data_r  <= 1'b0;
      done_ctrl_r  <= 1'b0;
      fail_data_r  <= 1'b0;
      fail_ctrl_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      last_grant_r <= last_grant_nxt;
      timer_r      <= timer_nxt;
      retry_r      <= retry_nxt;
      success_r    <= success_nxt;
      grant_data_r <= grant_data_nxt;
      grant_ctrl_r <= grant_ctrl_nxt;
      start_tx_r   <= start_tx_nxt;
      done_data_r  <= done_data_nxt;
      done_ctrl_r  <= done_ctrl_nxt;
      fail_data_r  <= fail_data_nxt;
      fail_ctrl_r  <= fail_ctrl_nxt;
    end
  end

  assign grant_data  = grant_data_r;
  assign grant_ctrl  = grant_ctrl_r;
  assign start_tx    = start_tx_r;
  assign done_data   = done_data_r;
  assign done_ctrl   = done_ctrl_r;
  assign fail_data   = fail_data_r;
  assign fail_ctrl   = fail_ctrl_r;
  assign retry_count = retry_r;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Testbench for usb_tx_arbiter. The driver runs transactions with
// randomized acknowledgement and backoff timing. A transaction-level
// reference model predicts the winner, outcome, retry count and total
// duration, and queues that prediction. A negedge monitor pops and compares
// it when a done/fail pulse appears.
module tb_usb_tx_arbiter;

  localparam int T    = 16;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       req_data;
  logic       req_ctrl;
  logic       handshake_ack;
  logic       idle_transmitting;
  logic       grant_data;
  logic       grant_ctrl;
  logic       start_tx;
  logic       done_data;
  logic       done_ctrl;
  logic       fail_data;
  logic       fail_ctrl;
  logic [1:0] retry_count;

  typedef struct {
    bit win_ctrl;
    bit ok;
    int retries;
    int elapsed;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   vectors   = 0;
  int   errors    = 0;
  bit   mon_off   = 1'b1;
  bit   lg_ctrl   = 1'b0;
  bit   m_active  = 1'b0;
  int   m_first   = 0;
  int   m_nstarts = 0;
  int   cyc       = 0;

  usb_tx_arbiter #(
    .TIMEOUT_CYCLES(T),
    .MAX_RETRY     (MAXR),
    .CNT_W         (8)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .req_data         (req_data),
    .req_ctrl         (req_ctrl),
    .handshake_ack    (handshake_ack),
    .idle_transmitting(idle_transmitting),
    .grant_data       (grant_data),
    .grant_ctrl       (grant_ctrl),
    .start_tx         (start_tx),
    .done_data        (done_data),
    .done_ctrl        (done_ctrl),
    .fail_data        (fail_data),
    .fail_ctrl        (fail_ctrl),
    .retry_count      (retry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {23'd0, grant_data, grant_ctrl, start_tx, done_data, done_ctrl,
                 fail_data, fail_ctrl, retry_count}, 32'd0);
  endtask

  // One transaction: the model predicts the result, then the driver applies it.
  task automatic run_txn(input int pat, input logic [3:0] ack_mask, input int dsel,
                         input int bsel, input bit hold);
    int   d[4];
    int   b[4];
    int   na;
    int   el;
    bit   ok;
    exp_t e;
    for (int a = 0; a < 4; a++) begin
      if (dsel >= 0) d[a] = dsel;
      else d[a] = ($urandom_range(3, 0) == 0) ? T - 1 : int'($urandom_range(T - 1, 0));
      b[a] = (bsel >= 0) ? bsel : int'($urandom_range(2, 0));
    end
    // Reference model: round-robin winner, first acknowledged attempt, durations
    e.win_ctrl = (pat == 2) || (pat == 3 && !lg_ctrl);
    lg_ctrl    = e.win_ctrl;
    ok = 1'b0;
    na = MAXR;
    for (int a = 0; a <= MAXR; a++) begin
      if (!ok && ack_mask[a]) begin
        ok = 1'b1;
        na = a;
      end
    end
    el = 0;
    for (int a = 0; a < na; a++) el += 1 + T + (b[a] + 1);
    el += ok ? (2 + d[na]) : (1 + T);
    e.ok      = ok;
    e.retries = na;
    e.elapsed = el;
    exp_q.push_back(e);

    // Drive the transaction
    req_data = ((pat & 1) != 0);
    req_ctrl = ((pat & 2) != 0);
    @(posedge clk); #1;
    check("req_to_start", {31'd0, start_tx}, 32'd1);
    for (int a = 0; a <= na; a++) begin
      if (!hold) begin
        req_data = 1'b0;
        req_ctrl = 1'b0;
      end
      handshake_ack = 1'($urandom_range(1, 0));
      for (int k = 0; k < T; k++) begin
        @(posedge clk); #1;
        handshake_ack = (ok && a == na && k == d[a]);
        if (ok && a == na && k == d[a]) break;
        if (k == T - 1 && a < na) idle_transmitting = (b[a] == 0);
      end
      if (a < na) begin
        for (int j = 0; j <= b[a]; j++) begin
          @(posedge clk); #1;
          handshake_ack = 1'($urandom_range(1, 0));
          if (j == b[a]) idle_transmitting = 1'b1;
        end
        @(posedge clk); #1;
        check("retry_start", {31'd0, start_tx}, 32'd1);
      end
    end
    @(posedge clk); #1;
    handshake_ack = 1'($urandom_range(1, 0));
    req_data = 1'b0;
    req_ctrl = 1'b0;
    repeat ($urandom_range(3, 1)) begin
      @(posedge clk); #1;
      handshake_ack = 1'($urandom_range(1, 0));
    end
    handshake_ack = 1'b0;
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on each outcome pulse
  always @(negedge clk) begin
    cyc++;
    if (mon_off) begin
      m_active  = 1'b0;
      m_nstarts = 0;
    end else begin
      check("grant_exclusive", {31'd0, grant_data & grant_ctrl}, 32'd0);
      if (start_tx) begin
        if (exp_q.size() == 0) begin
          check("start_without_request", exp_q.size(), 32'd1);
        end else begin
          if (!m_active) begin
            m_active  = 1'b1;
            m_first   = cyc;
            m_nstarts = 0;
          end
          check("retry_at_start", {30'd0, retry_count}, m_nstarts);
          m_nstarts++;
        end
      end
      if (m_active && exp_q.size() > 0) begin
        check("grant_held", {30'd0, grant_data, grant_ctrl},
              {30'd0, !exp_q[0].win_ctrl, exp_q[0].win_ctrl});
      end else if (!start_tx) begin
        check("grant_idle", {30'd0, grant_data, grant_ctrl}, 32'd0);
      end
      if (done_data || done_ctrl || fail_data || fail_ctrl) begin
        if (exp_q.size() == 0) begin
          check("pulse_without_request", {28'd0, done_data, done_ctrl, fail_data, fail_ctrl}, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          check("outcome_pulse", {28'd0, done_data, done_ctrl, fail_data, fail_ctrl},
                {28'd0, m_e.ok && !m_e.win_ctrl, m_e.ok && m_e.win_ctrl,
                 !m_e.ok && !m_e.win_ctrl, !m_e.ok && m_e.win_ctrl});
          check("retry_count", {30'd0, retry_count}, m_e.retries);
          check("attempts", m_nstarts, m_e.retries + 1);
          check("latency", cyc - m_first, m_e.elapsed);
        end
        m_active = 1'b0;
      end
    end
  end

  // Stimulus sequence
  initial begin
    n_rst             = 1'b0;
    req_data          = 1'b1;
    req_ctrl          = 1'b1;
    handshake_ack     = 1'b0;
    idle_transmitting = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_cycle1");
    @(posedge clk); #1;
    check_zero("reset_cycle2");
    n_rst   = 1'b1;
    mon_off = 1'b0;

    run_txn(3, 4'b0001, 9, 0, 1'b0);
    run_txn(1, 4'b0001, 9, 0, 1'b0);
    repeat (4) run_txn(3, 4'b0001, 4, 0, 1'b1);
    run_txn(1, 4'b0000, 0, 0, 1'b0);
    run_txn(2, 4'b0001, T - 1, 0, 1'b0);
    run_txn(1, 4'b1000, -1, -1, 1'b0);
    run_txn(2, 4'b0100, -1, -1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      run_txn(int'($urandom_range(3, 1)), 4'($urandom_range(15, 0)), -1, -1,
              1'($urandom_range(1, 0)));
    end

    // Reset in the middle of the second attempt
    mon_off  = 1'b1;
    req_data = 1'b1;
    req_ctrl = 1'b0;
    @(posedge clk); #1;
    req_data = 1'b0;
    repeat (T) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_start2", {31'd0, start_tx}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_retry_pre", {30'd0, retry_count}, 32'd1);
    check("mid_grant_pre", {30'd0, grant_data, grant_ctrl}, 32'd2);
    n_rst = 1'b0;
    @(posedge clk); #1;
    check_zero("mid_reset");
    n_rst   = 1'b1;
    lg_ctrl = 1'b0;
    mon_off = 1'b0;
    run_txn(3, 4'b0001, 2, 0, 1'b0);
    run_txn(3, 4'b0011, 5, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
